// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetch stage: credit-limited sequential fetch, in-order prefetch FIFO,
// redirect flush with in-flight response discard. Optional stall counter under FETCH_PERF_EN.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_stall_cycles
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0]   CreditMax = (CntW + 1)'(DEPTH);
  localparam logic [CntW-1:0] CntMax    = CntW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CntW:0]   credit_used;
  logic [31:0]     redirect_base;
  logic            unused_redirect_lsb;

  assign redirect_base       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credits cover both buffered and in-flight words, so a response always has a free slot.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < CreditMax);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = imem_resp_valid && !redirect_valid && (discard_q == '0);

  // Storage is not reset; gating keeps the outputs at zero while the FIFO is empty.
  assign inst_out = inst_valid ? data_mem[rd_ptr_q] : '0;
  assign inst_pc  = inst_valid ? pc_mem[rd_ptr_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(imem_resp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      // Everything still owed by memory belongs to the old stream.
      discard_d  = inflight_q - CntW'(imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_resp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CntW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      data_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (inst_ready && !inst_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cycles = stall_cnt_q;
`endif

  count_in_range: assert property (@(posedge clk) disable iff (reset) count_q <= CntMax);
  credit_in_range: assert property (@(posedge clk) disable iff (reset) credit_used <= CreditMax);
  discard_le_inflight: assert property (@(posedge clk) disable iff (reset)
    discard_q <= inflight_q);
  resp_has_request: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (inflight_q != '0));

endmodule
